// File: rtl/accum_buffer.sv
// accum_buffer: double-buffered partial-sum accumulator for one systolic-array column.
//
// The write bank (W) sums the column's ofmap stream over num_passes passes into ACC_DEPTH
// slots. When a tile completes, W and R swap: R is streamed out in slot order over a
// valid/ready handshake while the next tile accumulates into the new W.
//
// Optional feature macro: ACC_SATURATE_EN
//   defined   -> accumulation saturates to the signed OFMAP_WIDTH range on overflow
//   undefined -> two's-complement wrap-around
// Pass-0 overwrites are stored verbatim in both builds.

module accum_buffer #(
  parameter int unsigned OFMAP_WIDTH = 32,
  parameter int unsigned ACC_DEPTH   = 16,
  parameter int unsigned ADDR_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   config_en,
  input  logic [7:0]             num_passes,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OFMAP_WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OFMAP_WIDTH-1:0] out_data
);

  localparam logic [ADDR_WIDTH-1:0] LastSlot = ADDR_WIDTH'(ACC_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PtrOne   = ADDR_WIDTH'(1);

`ifdef ACC_SATURATE_EN
  localparam logic [OFMAP_WIDTH-1:0] SatMax = {1'b0, {(OFMAP_WIDTH-1){1'b1}}};
  localparam logic [OFMAP_WIDTH-1:0] SatMin = {1'b1, {(OFMAP_WIDTH-1){1'b0}}};
`endif

  // Bank storage: index 0/1 selected by bank_sel_q (W) and its complement (R).
  logic [OFMAP_WIDTH-1:0] bank_mem [0:1][0:ACC_DEPTH-1];

  // Control state
  logic                  bank_sel_q, bank_sel_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]            pass_cnt_q, pass_cnt_d;
  logic [7:0]            num_passes_q, num_passes_d;
  logic                  r_full_q, r_full_d;
  logic                  wr_hold_q, wr_hold_d;

  // Decoded events
  logic wr_fire;
  logic last_slot;
  logic last_pass;
  logic tile_done;
  logic rd_fire;
  logic rd_last;
  logic r_free;
  logic swap;
  logic idle;

  // Datapath
  logic                   wr_bank;
  logic                   rd_bank;
  logic [OFMAP_WIDTH-1:0] acc_old;
  logic [OFMAP_WIDTH-1:0] acc_sum;
  logic [OFMAP_WIDTH-1:0] acc_next;
  logic [OFMAP_WIDTH-1:0] wr_value;

  assign wr_bank = bank_sel_q;
  assign rd_bank = ~bank_sel_q;

  // Handshake outputs: input stalls only while a finished W tile waits for R to drain.
  always_comb begin
    in_ready  = ~wr_hold_q;
    out_valid = r_full_q;
    out_data  = bank_mem[rd_bank][rd_ptr_q];
  end

  // Event decode for the write and read sides.
  always_comb begin
    wr_fire   = in_valid && in_ready;
    last_slot = (wr_ptr_q == LastSlot);
    // num_passes of 0 behaves as a single pass.
    if (num_passes_q <= 8'd1) begin
      last_pass = (pass_cnt_q == 8'd0);
    end else begin
      last_pass = (pass_cnt_q == (num_passes_q - 8'd1));
    end
    tile_done = wr_fire && last_slot && last_pass;
    rd_fire   = out_valid && out_ready;
    rd_last   = rd_fire && (rd_ptr_q == LastSlot);
    // R counts as free when already empty or when its final pop happens this cycle.
    r_free    = ~r_full_q || rd_last;
    swap      = (tile_done || wr_hold_q) && r_free;
    idle      = (wr_ptr_q == '0) && (pass_cnt_q == 8'd0) && ~wr_hold_q;
  end

  // Accumulate in_data into the addressed W slot, with optional saturation.
  always_comb begin
    acc_old  = bank_mem[wr_bank][wr_ptr_q];
    acc_sum  = acc_old + in_data;
    acc_next = acc_sum;
`ifdef ACC_SATURATE_EN
    // Signed overflow: operands agree in sign but the sum does not.
    if ((acc_old[OFMAP_WIDTH-1] == in_data[OFMAP_WIDTH-1]) &&
        (acc_sum[OFMAP_WIDTH-1] != acc_old[OFMAP_WIDTH-1])) begin
      acc_next = acc_old[OFMAP_WIDTH-1] ? SatMin : SatMax;
    end
`endif
    wr_value = (pass_cnt_q == 8'd0) ? in_data : acc_next;
  end

  // Next-state logic for pointers, pass counter, bank swap and configuration.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    pass_cnt_d   = pass_cnt_q;
    rd_ptr_d     = rd_ptr_q;
    bank_sel_d   = bank_sel_q;
    r_full_d     = r_full_q;
    wr_hold_d    = wr_hold_q;
    num_passes_d = num_passes_q;

    if (wr_fire) begin
      if (last_slot) begin
        wr_ptr_d   = '0;
        pass_cnt_d = last_pass ? 8'd0 : (pass_cnt_q + 8'd1);
      end else begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
    end

    if (rd_fire) begin
      rd_ptr_d = rd_last ? '0 : (rd_ptr_q + PtrOne);
    end

    if (swap) begin
      bank_sel_d = ~bank_sel_q;
      r_full_d   = 1'b1;
      wr_hold_d  = 1'b0;
    end else begin
      if (rd_last) begin
        r_full_d = 1'b0;
      end
      if (tile_done) begin
        wr_hold_d = 1'b1;
      end
    end

    // New pass count only between tiles; it governs the next tile.
    if (config_en && idle) begin
      num_passes_d = num_passes;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pass_cnt_q   <= 8'd0;
      num_passes_q <= 8'd1;
      r_full_q     <= 1'b0;
      wr_hold_q    <= 1'b0;
    end else begin
      bank_sel_q   <= bank_sel_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pass_cnt_q   <= pass_cnt_d;
      num_passes_q <= num_passes_d;
      r_full_q     <= r_full_d;
      wr_hold_q    <= wr_hold_d;
    end
  end

  // Bank storage: cleared on reset so out_data reads zero, written one slot per transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < int'(ACC_DEPTH); i++) begin
          bank_mem[b][i] <= '0;
        end
      end
    end else if (wr_fire) begin
      bank_mem[wr_bank][wr_ptr_q] <= wr_value;
    end
  end

  // A held tile always implies R is still occupied.
  hold_implies_full_a : assert property (@(posedge clk) disable iff (!rst_n)
    wr_hold_q |-> r_full_q);

  // Presented output must not change while the consumer stalls.
  out_stable_a : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_accum_buffer.sv
// tb_accum_buffer: table-driven tiles plus directed backpressure, config-gating and reset
// sequences. Expected ofmaps go into a queue when a tile is driven and are popped by a
// monitor on every output handshake.

module tb_accum_buffer;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int AW = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         config_en;
  logic [7:0]   num_passes;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  accum_buffer #(
    .OFMAP_WIDTH(W),
    .ACC_DEPTH  (D),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .config_en (config_en),
    .num_passes(num_passes),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]          np;
    logic signed [W-1:0] p0 [D];
    logic signed [W-1:0] p1 [D];
    logic signed [W-1:0] ex [D];
  } vec_t;

  vec_t         vecs [4];
  vec_t         ones;
  logic [W-1:0] exp_q [$];
  int           n_vec = 0;
  int           n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Scoreboard monitor: sample at negedge, pop happens on the following posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL out_data: got %h, expected no output", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [W-1:0] d);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!in_ready) check_bit("in_ready_timeout", in_ready, 1'b1);
    tick();
  endtask

  task automatic configure(input logic [7:0] np);
    config_en  = 1'b1;
    num_passes = np;
    tick();
    config_en  = 1'b0;
  endtask

  task automatic push_exp(input vec_t v);
    for (int s = 0; s < D; s++) exp_q.push_back(v.ex[s]);
  endtask

  // Drive one tile (at most two distinct pass tables), expected values queued up front.
  task automatic run_tile(input vec_t v);
    int eff;
    eff = (v.np == 8'd0) ? 1 : int'(v.np);
    push_exp(v);
    for (int p = 0; p < eff; p++) begin
      for (int s = 0; s < D; s++) write_word((p == 0) ? v.p0[s] : v.p1[s]);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    check("drain_empty", W'(exp_q.size()), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0].np = 8'd2;
    vecs[0].p0 = '{1, 2, 3, 4};
    vecs[0].p1 = '{10, -20, 30, -40};
    vecs[0].ex = '{11, -18, 33, -36};

    vecs[1].np = 8'd0;
    vecs[1].p0 = '{5, 6, 7, 8};
    vecs[1].p1 = '{0, 0, 0, 0};
    vecs[1].ex = '{5, 6, 7, 8};

    vecs[2].np = 8'd1;
    vecs[2].p0 = '{-1, 0, 100, 32'sh8000_0000};
    vecs[2].p1 = '{0, 0, 0, 0};
    vecs[2].ex = '{-1, 0, 100, 32'sh8000_0000};

    // Positive and negative overflow in slots 0, 1 and 3; slot 2 is an ordinary sum.
    vecs[3].np = 8'd2;
    vecs[3].p0 = '{32'sh7FFF_FFF0, 32'sh8000_0010, 5, 32'sh4000_0000};
    vecs[3].p1 = '{32'sh0000_0020, -32, -7, 32'sh4000_0000};
`ifdef ACC_SATURATE_EN
    vecs[3].ex = '{32'sh7FFF_FFFF, 32'sh8000_0000, -2, 32'sh7FFF_FFFF};
`else
    vecs[3].ex = '{32'sh8000_0010, 32'sh7FFF_FFF0, -2, 32'sh8000_0000};
`endif

    ones.np = 8'd2;
    ones.p0 = '{1, 1, 1, 1};
    ones.p1 = '{1, 1, 1, 1};
    ones.ex = '{2, 2, 2, 2};

    rst_n      = 1'b0;
    config_en  = 1'b0;
    num_passes = 8'd0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("reset_in_ready", in_ready, 1'b1);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, '0);
    rst_n = 1'b1;
    tick();

    // Default pass count after reset is one.
    out_ready = 1'b1;
    exp_q.push_back(32'd9); exp_q.push_back(32'd8);
    exp_q.push_back(32'd7); exp_q.push_back(32'd6);
    write_word(32'd9); write_word(32'd8); write_word(32'd7); write_word(32'd6);
    in_valid = 1'b0;
    check_bit("default_single_pass_valid", out_valid, 1'b1);
    drain();

    // Table: each tile is presented the cycle after its last write.
    for (int i = 0; i < 4; i++) begin
      configure(vecs[i].np);
      run_tile(vecs[i]);
      check_bit("valid_after_last_write", out_valid, 1'b1);
      check("slot0_after_last_write", out_data, vecs[i].ex[0]);
    end
    drain();

    // Backpressure: second finished tile holds the input until R fully drains.
    out_ready = 1'b0;
    configure(8'd2);
    run_tile(vecs[0]);
    check_bit("bp_tile1_valid", out_valid, 1'b1);
    run_tile(vecs[3]);
    check_bit("bp_in_ready_low", in_ready, 1'b0);
    check("bp_tile1_slot0", out_data, vecs[0].ex[0]);
    repeat (3) tick();
    check_bit("bp_in_ready_still_low", in_ready, 1'b0);
    check("bp_data_stable", out_data, vecs[0].ex[0]);
    out_ready = 1'b1;
    for (int k = 1; k <= D; k++) begin
      tick();
      check_bit("bp_in_ready_after_pop", in_ready, (k == D));
    end
    check_bit("bp_tile2_valid", out_valid, 1'b1);
    check("bp_tile2_slot0", out_data, vecs[3].ex[0]);
    drain();

    // Config gating: request mid-tile is ignored, tile ends after two passes.
    configure(8'd2);
    exp_q.push_back(32'd6); exp_q.push_back(32'd8);
    exp_q.push_back(32'd10); exp_q.push_back(32'd12);
    write_word(32'd1); write_word(32'd2);
    in_valid = 1'b0;
    configure(8'd3);
    write_word(32'd3); write_word(32'd4);
    write_word(32'd5); write_word(32'd6); write_word(32'd7); write_word(32'd8);
    in_valid = 1'b0;
    check_bit("cfg_ignored_valid", out_valid, 1'b1);
    drain();
    configure(8'd3);
    exp_q.push_back(32'd3); exp_q.push_back(32'd6);
    exp_q.push_back(32'd9); exp_q.push_back(32'd12);
    for (int n = 0; n < 3 * D; n++) begin
      write_word(W'(n % D + 1));
      if (n == 2 * D - 1) check_bit("cfg3_not_done_at_8", out_valid, 1'b0);
    end
    in_valid = 1'b0;
    check_bit("cfg3_done_at_12", out_valid, 1'b1);
    drain();

    // Reset mid-operation with a pending output tile and a partial tile.
    out_ready = 1'b0;
    configure(8'd2);
    run_tile(vecs[0]);
    for (int n = 0; n < 6; n++) write_word(32'd77);
    in_valid = 1'b0;
    check_bit("pre_reset_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("mid_reset_out_valid", out_valid, 1'b0);
    check_bit("mid_reset_in_ready", in_ready, 1'b1);
    check("mid_reset_out_data", out_data, '0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    configure(8'd2);
    run_tile(ones);
    check_bit("post_reset_valid", out_valid, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
